// File: rtl/key_pkg.sv
// Shared constants and state type for the key conditioning slice.
// Bit map: SD SU MD MU HD HU EXPORT LEAD CS.
package key_pkg;
  localparam int N_KEYS = 9;
  localparam int K_SD = 0;
  localparam int K_SU = 1;
  localparam int K_MD = 2;
  localparam int K_MU = 3;
  localparam int K_HD = 4;
  localparam int K_HU = 5;
  localparam int K_EXPORT = 6;
  localparam int K_LEAD = 7;
  localparam int K_CS = 8;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } key_state_t;
endpackage

// File: rtl/key_channel.sv
// One key: 2-flop sync, debounce, press/release pulses, auto-repeat.
// The FSM reacts to the debounce decision made on the same edge.
module key_channel
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 200,
  parameter int REPEAT_DELAY = 5000,
  parameter int REPEAT_PERIOD = 1000,
  parameter bit RPT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic s1, s2;
  logic [DW-1:0] db_cnt, db_nx;
  logic [RW-1:0] rc, rc_nx;
  key_state_t state, state_nx;
  logic level_nx, pulse_nx, rel_nx;
  logic accept, rise, fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      db_cnt <= '0;
      state <= IDLE;
      rc <= '0;
      pulse <= 1'b0;
      rel <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      level <= level_nx;
      db_cnt <= db_nx;
      state <= state_nx;
      rc <= rc_nx;
      pulse <= pulse_nx;
      rel <= rel_nx;
    end
  end

  always_comb begin
    accept = (s2 != level) && (db_cnt == DW'(DB_CYCLES - 1));
    rise = accept & s2;
    fall = accept & ~s2;
    level_nx = accept ? s2 : level;
    if ((s2 == level) || accept) db_nx = '0;
    else db_nx = db_cnt + DW'(1);
  end

  // Release wins over any repeat due on the same edge.
  always_comb begin
    state_nx = state;
    rc_nx = rc;
    pulse_nx = 1'b0;
    rel_nx = 1'b0;
    if (fall) begin
      state_nx = IDLE;
      rc_nx = '0;
      rel_nx = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nx = HELD;
            rc_nx = '0;
            pulse_nx = 1'b1;
          end
        end
        HELD: begin
          if (RPT_EN && rc == RW'(REPEAT_DELAY - 1)) begin
            state_nx = REPEAT;
            rc_nx = '0;
            pulse_nx = 1'b1;
          end else if (rc != RW'(REPEAT_DELAY)) begin
            rc_nx = rc + RW'(1);
          end
        end
        REPEAT: begin
          if (rc == RW'(REPEAT_PERIOD - 1)) begin
            rc_nx = '0;
            pulse_nx = 1'b1;
          end else begin
            rc_nx = rc + RW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// Nine-key conditioner: per-key channels plus pair conflict masking.
// Paired up/down keys both held suppress each other's pulses.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 200,
  parameter int REPEAT_DELAY = 5000,
  parameter int REPEAT_PERIOD = 1000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = 9'b000111111
) (
  input  logic CP,
  input  logic CR,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PULSE,
  output logic [N_KEYS-1:0] KEY_RELEASE
);
  logic [N_KEYS-1:0] pulse_raw;
  logic [N_KEYS-1:0] sup;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DB_CYCLES(DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_EN(REPEAT_MASK[i])
    ) u_ch (
      .clk(CP),
      .rst_n(CR),
      .raw(KEY_IN[i]),
      .level(KEY_LEVEL[i]),
      .pulse(pulse_raw[i]),
      .rel(KEY_RELEASE[i])
    );
  end

  always_comb begin
    sup = '0;
    if (KEY_LEVEL[K_SD] & KEY_LEVEL[K_SU]) begin
      sup[K_SD] = 1'b1;
      sup[K_SU] = 1'b1;
    end
    if (KEY_LEVEL[K_MD] & KEY_LEVEL[K_MU]) begin
      sup[K_MD] = 1'b1;
      sup[K_MU] = 1'b1;
    end
    if (KEY_LEVEL[K_HD] & KEY_LEVEL[K_HU]) begin
      sup[K_HD] = 1'b1;
      sup[K_HU] = 1'b1;
    end
  end

  assign KEY_PULSE = pulse_raw & ~sup;
endmodule
